addsub_pipe: RTL and testbench

Parametrised, pipelined adder/subtractor with valid/ready handshake. Carry ripples across `STAGES` register stages of `WIDTH/STAGES` bits each, so wide operands close timing at full throughput. It is the sequential, width-generalised successor of the 8-bit combinational `adder_sub`. It adds signed-overflow and zero flags, back-pressure, and an explicit op encoding in place of separate add/sub enables.

---
 rtl/addsub_pkg.sv | 28 ++
 rtl/addsub_seg.sv | 15 +
 rtl/addsub_pipe.sv | 126 ++++++++++++
 tb/tb_addsub_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types for the pipelined adder/subtractor: op encoding and the
// per-stage control record that travels alongside the data segments.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_RSVD = 2'b11
  } addsub_op_t;

  // Width-independent part of a stage record. The width-dependent part
  // (partial result, pending operands) is added inside addsub_pipe, where
  // WIDTH is known.
  typedef struct packed {
    logic       valid;
    addsub_op_t op;
    logic       a_msb;
    logic       b_msb;
    logic       carry;
  } addsub_ctl_t;

  // ADD and SUB produce flags; NOP and the reserved code just pass a through.
  function automatic logic op_is_arith(addsub_op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// Combinational segment adder: one WIDTH/STAGES-bit slice of the carry chain.
module addsub_seg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Widen by one bit so the segment carry falls out of the sum.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor. Each stage resolves one segment of the carry
// chain; the whole pipe advances together and stalls on output back-pressure.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             out_en
);

  localparam int SEG = WIDTH / STAGES;

  // res fills from the top and shifts down one segment per stage, so after
  // the last stage it holds the full result in natural order. pa/pb shift
  // down the same way, so every stage reads its segment from the low bits.
  typedef struct packed {
    addsub_ctl_t      ctl;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
  } stage_t;

  stage_t           src     [STAGES];
  stage_t           nxt     [STAGES];
  stage_t           st      [STAGES];
  logic [SEG-1:0]   seg_sum [STAGES];
  logic             seg_cout[STAGES];
  stage_t           last;
  addsub_op_t       in_op;
  logic             adv;
  logic             is_add;
  logic             is_sub;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage inputs: stage 0 takes the conditioned operands, later stages take
  // the previous stage register. SUB is a + ~b + !carry_in; NOP adds zero.
  always_comb begin
    in_op  = addsub_op_t'(op);
    src[0] = '0;
    src[0].ctl.valid = in_valid;
    src[0].ctl.op    = in_op;
    src[0].ctl.a_msb = a[WIDTH-1];
    src[0].ctl.b_msb = b[WIDTH-1];
    src[0].pa        = a;
    case (in_op)
      OP_ADD: begin
        src[0].pb        = b;
        src[0].ctl.carry = carry_in;
      end
      OP_SUB: begin
        src[0].pb        = ~b;
        src[0].ctl.carry = !carry_in;
      end
      default: begin
        src[0].pb        = '0;
        src[0].ctl.carry = 1'b0;
      end
    endcase
    for (int k = 1; k < STAGES; k++) begin
      src[k] = st[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_seg
    addsub_seg #(.W(SEG)) u_seg (
      .a    (src[g].pa[SEG-1:0]),
      .b    (src[g].pb[SEG-1:0]),
      .cin  (src[g].ctl.carry),
      .sum  (seg_sum[g]),
      .cout (seg_cout[g])
    );
  end

  // Next stage contents: merge the new segment into the result, retire it
  // from the pending operands, and forward the segment carry.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt[k]           = src[k];
      nxt[k].ctl.carry = seg_cout[k];
      nxt[k].res       = (src[k].res >> SEG) | (WIDTH'(seg_sum[k]) << (WIDTH - SEG));
      nxt[k].pa        = src[k].pa >> SEG;
      nxt[k].pb        = src[k].pb >> SEG;
    end
  end

  // Stage registers: cleared on reset (drops in-flight ops), held on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) st[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) st[k] <= nxt[k];
    end
  end

  // Outputs decode only the last stage register, so there is no path from
  // a/b, and everything reads zero straight out of reset.
  assign last      = st[STAGES-1];
  assign is_add    = last.ctl.op == OP_ADD;
  assign is_sub    = last.ctl.op == OP_SUB;
  assign out_valid = last.ctl.valid;
  assign data_out  = last.res;
  assign carry_out = out_valid && ((is_add && last.ctl.carry) || (is_sub && !last.ctl.carry));
  assign overflow  = out_valid && (last.res[WIDTH-1] != last.ctl.a_msb) &&
                     ((is_add && (last.ctl.a_msb == last.ctl.b_msb)) ||
                      (is_sub && (last.ctl.a_msb != last.ctl.b_msb)));
  assign zero      = out_valid && (last.res == '0);
  assign out_en    = out_valid && op_is_arith(last.ctl.op);

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: one 8-bit/2-stage and one 32-bit/4-stage
// instance, checked against an arithmetic reference model.
module tb_addsub_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v8 = 0, r8, ordy8 = 1, ov8, co8, of8, z8, en8, ci8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, d8;
  logic [1:0]  op8 = 0;
  logic        v32 = 0, r32, ordy32 = 1, ov32, co32, of32, z32, en32, ci32 = 0;
  logic [31:0] a32 = 0, b32 = 0, d32;
  logic [1:0]  op32 = 0;

  int n_pass = 0;
  int n_total = 0;
  int emitted8 = 0;
  int emitted32 = 0;
  logic done8 = 0, done32 = 0;
  logic [35:0] q8[$];
  logic [35:0] q32[$];

  addsub_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
    .op(op8), .carry_in(ci8), .out_valid(ov8), .out_ready(ordy8),
    .data_out(d8), .carry_out(co8), .overflow(of8), .zero(z8), .out_en(en8));

  addsub_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .a(a32), .b(b32),
    .op(op32), .carry_in(ci32), .out_valid(ov32), .out_ready(ordy32),
    .data_out(d32), .carry_out(co32), .overflow(of32), .zero(z32), .out_en(en32));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: unsigned sums for data/carry, signed sums for overflow.
  // Packed as {data[31:0], carry, overflow, zero, out_en}.
  function automatic logic [35:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic [1:0] op,
                                        input logic cin);
    longint mask, ua, ub, sa, sb, c, full, rs, lim;
    logic [31:0] d;
    logic co, of, en;
    mask = (longint'(1) << w) - 1;
    lim  = longint'(1) << (w - 1);
    ua = longint'({32'b0, a}) & mask;
    ub = longint'({32'b0, b}) & mask;
    c  = cin ? 1 : 0;
    sa = (ua >= lim) ? ua - 2 * lim : ua;
    sb = (ub >= lim) ? ub - 2 * lim : ub;
    en = (op == 2'b01) || (op == 2'b10);
    case (op)
      2'b01: begin full = ua + ub + c; co = full[w]; rs = sa + sb + c; end
      2'b10: begin full = ua - ub - c; co = ua < ub + c; rs = sa - sb - c; end
      default: begin full = ua; co = 1'b0; rs = 0; end
    endcase
    d  = 32'(full & mask);
    of = en && (rs > lim - 1 || rs < -lim);
    return {d, co, of, d == 32'b0, en};
  endfunction

  // 8-bit monitor: record accepted inputs, check emitted outputs and stalls.
  initial begin : mon8
    logic [12:0] snap, cur;
    logic held;
    logic [35:0] e;
    held = 0; snap = 0;
    forever begin
      @(negedge clk);
      if (rst) held = 0;
      else begin
        cur = {ov8, d8, co8, of8, z8, en8};
        chk("in_ready8", 64'(r8), 64'(!ov8 || ordy8));
        if (held) chk("stall_hold8", 64'(cur), 64'(snap));
        if (v8 && r8) q8.push_back(model(8, {24'b0, a8}, {24'b0, b8}, op8, ci8));
        if (ov8 && ordy8) begin
          if (q8.size() == 0) chk("unexpected_out8", 64'(1), 64'(0));
          else begin
            e = q8.pop_front();
            chk("result8", 64'({24'b0, d8, co8, of8, z8, en8}), 64'(e));
            emitted8++;
          end
        end
        held = ov8 && !ordy8;
        snap = cur;
      end
    end
  end

  initial begin : mon32
    logic [36:0] snap, cur;
    logic held;
    logic [35:0] e;
    held = 0; snap = 0;
    forever begin
      @(negedge clk);
      if (rst) held = 0;
      else begin
        cur = {ov32, d32, co32, of32, z32, en32};
        chk("in_ready32", 64'(r32), 64'(!ov32 || ordy32));
        if (held) chk("stall_hold32", 64'(cur), 64'(snap));
        if (v32 && r32) q32.push_back(model(32, a32, b32, op32, ci32));
        if (ov32 && ordy32) begin
          if (q32.size() == 0) chk("unexpected_out32", 64'(1), 64'(0));
          else begin
            e = q32.pop_front();
            chk("result32", 64'({d32, co32, of32, z32, en32}), 64'(e));
            emitted32++;
          end
        end
        held = ov32 && !ordy32;
        snap = cur;
      end
    end
  end

  // Drivers: called at posedge+1, return at posedge+1 after the accept edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic cin);
    logic ok;
    ok = 0;
    v8 = 1; a8 = a; b8 = b; op8 = op; ci8 = cin;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (r8) begin ok = 1; break; end
    end
    if (!ok) begin
      $display("FAIL send8_timeout: in_ready stuck low");
      $fatal(1, "send8 timeout");
    end
    @(posedge clk); #1;
    v8 = 0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic cin);
    logic ok;
    ok = 0;
    v32 = 1; a32 = a; b32 = b; op32 = op; ci32 = cin;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (r32) begin ok = 1; break; end
    end
    if (!ok) begin
      $display("FAIL send32_timeout: in_ready stuck low");
      $fatal(1, "send32 timeout");
    end
    @(posedge clk); #1;
    v32 = 0;
  endtask

  // Directed op on an idle pipe: result must appear exactly STAGES-1 edges after accept.
  task automatic direct8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic cin, input logic [7:0] ed, input logic eco, input logic eof);
    send8(a, b, op, cin);
    chk("lat8_early", 64'(ov8), 64'(0));
    @(posedge clk); #1;
    chk("lat8_valid", 64'(ov8), 64'(1));
    chk("dir8_value", 64'({d8, co8, of8}), 64'({ed, eco, eof}));
    @(posedge clk); #1;
  endtask

  task automatic direct32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic cin, input logic [31:0] ed, input logic eco, input logic ez);
    send32(a, b, op, cin);
    chk("lat32_early", 64'(ov32), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("lat32_early2", 64'(ov32), 64'(0));
    @(posedge clk); #1;
    chk("lat32_valid", 64'(ov32), 64'(1));
    chk("dir32_value", 64'({d32, co32, z32}), 64'({ed, eco, ez}));
    @(posedge clk); #1;
  endtask

  initial begin : main
    logic [7:0] cv [8];
    logic [1:0] bp_ops [6];
    int e0;
    cv = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55};
    bp_ops = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b11, 2'b10};

    ordy8 = 0; ordy32 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst8_outs", 64'({ov8, d8, co8, of8, z8, en8}), 64'(0));
    chk("rst8_in_ready", 64'(r8), 64'(1));
    chk("rst32_outs", 64'({ov32, d32, co32, of32, z32, en32}), 64'(0));
    chk("rst32_in_ready", 64'(r32), 64'(1));
    ordy8 = 1; ordy32 = 1;
    rst = 0;
    @(posedge clk); #1;

    direct8(8'd200, 8'd100, 2'b01, 1'b0, 8'd44, 1'b1, 1'b0);
    chk("add8_flags", 64'({z8, en8}), 64'(0));
    direct8(8'd5,   8'd7,   2'b10, 1'b0, 8'hFE, 1'b1, 1'b0);
    direct8(8'd127, 8'd1,   2'b01, 1'b0, 8'h80, 1'b0, 1'b1);
    direct8(8'h80,  8'd1,   2'b10, 1'b0, 8'h7F, 1'b0, 1'b1);
    direct8(8'h55,  8'h55,  2'b10, 1'b0, 8'h00, 1'b0, 1'b0);
    direct8(8'h33,  8'h44,  2'b00, 1'b1, 8'h33, 1'b0, 1'b0);
    direct32(32'h0000FFFF, 32'h1, 2'b01, 1'b0, 32'h00010000, 1'b0, 1'b0);
    direct32(32'hFFFFFFFF, 32'h0, 2'b01, 1'b1, 32'h0, 1'b1, 1'b1);

    // Back-pressure: six back-to-back ops, out_ready low for 3 cycles.
    e0 = emitted8;
    fork
      begin
        for (int i = 0; i < 6; i++) send8(8'($urandom), 8'($urandom), bp_ops[i], 1'($urandom));
      end
      begin
        for (int i = 0; i < 100 && !ov8; i++) @(negedge clk);
        @(posedge clk); #1;
        ordy8 = 0;
        repeat (3) @(posedge clk);
        #1;
        ordy8 = 1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("bp_count", 64'(emitted8 - e0), 64'(6));
    chk("bp_queue_empty", 64'(q8.size()), 64'(0));

    // Reset with two ops in flight in the 4-stage pipe.
    e0 = emitted32;
    send32(32'h12345678, 32'h1, 2'b01, 1'b0);
    send32(32'hDEADBEEF, 32'h2, 2'b10, 1'b0);
    #1;
    rst = 1;
    #1;
    q8.delete();
    q32.delete();
    chk("midrst_outs", 64'({ov32, d32, co32, of32, z32, en32}), 64'(0));
    chk("midrst_in_ready", 64'(r32), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    direct32(32'h80000000, 32'h80000000, 2'b01, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("midrst_no_ghost", 64'(emitted32 - e0), 64'(1));

    // Randomized traffic with random gaps and back-pressure on both instances.
    fork
      begin
        foreach (cv[i]) foreach (cv[j]) for (int c = 0; c < 2; c++) for (int o = 1; o < 3; o++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send8(cv[i], cv[j], 2'(o), 1'(c));
        end
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send8(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));
        end
        done8 = 1;
      end
      begin
        while (!done8) begin
          @(posedge clk); #1;
          ordy8 = ($urandom_range(0, 3) != 0);
        end
        ordy8 = 1;
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send32($urandom, ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom));
        end
        done32 = 1;
      end
      begin
        while (!done32) begin
          @(posedge clk); #1;
          ordy32 = ($urandom_range(0, 3) != 0);
        end
        ordy32 = 1;
      end
    join

    for (int i = 0; i < 500 && (q8.size() != 0 || q32.size() != 0); i++) @(posedge clk);
    #1;
    chk("drain8", 64'(q8.size()), 64'(0));
    chk("drain32", 64'(q32.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
